// File: rtl/hp_align_stage_if.sv
// Handshake channels for the binary16 add/sub front end.
// hp_in_if carries operand pairs in; hp_out_if carries the aligned result out.
interface hp_in_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] hp_inA;
  logic [15:0] hp_inB;
  logic        op;

  modport master (output in_valid, hp_inA, hp_inB, op, input in_ready);
  modport slave  (input in_valid, hp_inA, hp_inB, op, output in_ready);
endinterface

interface hp_out_if;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  big_exp;
  logic        sign_big;
  logic        sign_small;
  logic [13:0] mant_big;
  logic [13:0] mant_small;
  logic        eff_sub;
  logic        special_valid;
  logic [15:0] special_result;
  logic [1:0]  exceptions;

  modport master (output out_valid, big_exp, sign_big, sign_small, mant_big, mant_small,
                  eff_sub, special_valid, special_result, exceptions, input out_ready);
  modport slave  (input out_valid, big_exp, sign_big, sign_small, mant_big, mant_small,
                  eff_sub, special_valid, special_result, exceptions, output out_ready);
endinterface

// File: rtl/hp_align_stage.sv
// Two-stage binary16 add/sub front end: S1 unpacks, classifies and orders operands,
// S2 right-aligns the smaller mantissa with guard/round/sticky.
module hp_align_stage #(
  parameter int MW     = 14,
  parameter int SH_MAX = 13
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  hp_in_if.slave     in_bus,
  hp_out_if.master   out_bus
);
  localparam int FW = MW - 3;

  typedef struct packed {
    logic        valid;
    logic [15:0] result;
    logic [1:0]  exc;
  } spec_t;

  // b carries its post-op sign
  function automatic spec_t classify(input logic [15:0] a, input logic [15:0] b);
    logic nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    spec_t s;
    nan_a  = (&a[14:10]) & (|a[9:0]);
    nan_b  = (&b[14:10]) & (|b[9:0]);
    inf_a  = (&a[14:10]) & ~(|a[9:0]);
    inf_b  = (&b[14:10]) & ~(|b[9:0]);
    zero_a = ~(|a[14:0]);
    zero_b = ~(|b[14:0]);
    s = '0;
    if (nan_a | nan_b | (inf_a & inf_b & (a[15] ^ b[15])))
      s = '{1'b1, 16'h7E00, 2'b01};
    else if (inf_a)
      s = '{1'b1, {a[15], 15'h7C00}, 2'b10};
    else if (inf_b)
      s = '{1'b1, {b[15], 15'h7C00}, 2'b10};
    else if (zero_a & zero_b)
      s = '{1'b1, {a[15] & b[15], 15'h0000}, 2'b00};
    return s;
  endfunction

  // Anything shifted past bit 0 folds into the sticky bit.
  function automatic logic [MW-1:0] align_small(input logic [MW-1:0] m, input logic [4:0] sh);
    logic [MW-1:0] lost_mask;
    if (int'(sh) >= SH_MAX)
      return {{(MW-1){1'b0}}, |m};
    lost_mask = (MW'(1) << sh) - MW'(1);
    return (m >> sh) | {{(MW-1){1'b0}}, |(m & lost_mask)};
  endfunction

  logic          s1_valid_q, s1_valid_d;
  logic [4:0]    s1_big_exp_q, s1_big_exp_d;
  logic          s1_sign_big_q, s1_sign_big_d;
  logic          s1_sign_small_q, s1_sign_small_d;
  logic [FW-1:0] s1_mant_big_q, s1_mant_big_d;
  logic [FW-1:0] s1_mant_small_q, s1_mant_small_d;
  logic [4:0]    s1_diff_q, s1_diff_d;
  spec_t         s1_spec_q, s1_spec_d;

  logic          s2_valid_q, s2_valid_d;
  logic [4:0]    s2_big_exp_q, s2_big_exp_d;
  logic          s2_sign_big_q, s2_sign_big_d;
  logic          s2_sign_small_q, s2_sign_small_d;
  logic [MW-1:0] s2_mant_big_q, s2_mant_big_d;
  logic [MW-1:0] s2_mant_small_q, s2_mant_small_d;
  logic          s2_eff_sub_q, s2_eff_sub_d;
  spec_t         s2_spec_q, s2_spec_d;

  logic s1_load, s2_load;
  assign s2_load = ~s2_valid_q | out_bus.out_ready;
  assign s1_load = ~s1_valid_q | s2_load;
  assign in_bus.in_ready = s1_load;

  logic [15:0]   b_op;
  logic [4:0]    eexp_a, eexp_b;
  logic [FW-1:0] man_a, man_b;
  logic          a_big;

  always_comb begin
    b_op   = {in_bus.hp_inB[15] ^ in_bus.op, in_bus.hp_inB[14:0]};
    eexp_a = (in_bus.hp_inA[14:10] == 5'd0) ? 5'd1 : in_bus.hp_inA[14:10];
    eexp_b = (b_op[14:10] == 5'd0) ? 5'd1 : b_op[14:10];
    man_a  = {in_bus.hp_inA[14:10] != 5'd0, in_bus.hp_inA[9:0]};
    man_b  = {b_op[14:10] != 5'd0, b_op[9:0]};
    a_big  = in_bus.hp_inA[14:0] >= b_op[14:0];
  end

  always_comb begin
    s1_valid_d      = s1_valid_q;
    s1_big_exp_d    = s1_big_exp_q;
    s1_sign_big_d   = s1_sign_big_q;
    s1_sign_small_d = s1_sign_small_q;
    s1_mant_big_d   = s1_mant_big_q;
    s1_mant_small_d = s1_mant_small_q;
    s1_diff_d       = s1_diff_q;
    s1_spec_d       = s1_spec_q;
    s2_valid_d      = s2_valid_q;
    s2_big_exp_d    = s2_big_exp_q;
    s2_sign_big_d   = s2_sign_big_q;
    s2_sign_small_d = s2_sign_small_q;
    s2_mant_big_d   = s2_mant_big_q;
    s2_mant_small_d = s2_mant_small_q;
    s2_eff_sub_d    = s2_eff_sub_q;
    s2_spec_d       = s2_spec_q;

    if (s1_load) s1_valid_d = in_bus.in_valid;
    if (s2_load) s2_valid_d = s1_valid_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end

    // S1: unpack, order by magnitude, classify specials
    if (s1_load && in_bus.in_valid) begin
      s1_big_exp_d    = a_big ? eexp_a : eexp_b;
      s1_sign_big_d   = a_big ? in_bus.hp_inA[15] : b_op[15];
      s1_sign_small_d = a_big ? b_op[15] : in_bus.hp_inA[15];
      s1_mant_big_d   = a_big ? man_a : man_b;
      s1_mant_small_d = a_big ? man_b : man_a;
      s1_diff_d       = a_big ? (eexp_a - eexp_b) : (eexp_b - eexp_a);
      s1_spec_d       = classify(in_bus.hp_inA, b_op);
    end

    // S2: align the small mantissa; specials zero both mantissas
    if (s2_load && s1_valid_q) begin
      s2_big_exp_d    = s1_big_exp_q;
      s2_sign_big_d   = s1_sign_big_q;
      s2_sign_small_d = s1_sign_small_q;
      s2_eff_sub_d    = s1_sign_big_q ^ s1_sign_small_q;
      s2_spec_d       = s1_spec_q;
      s2_mant_big_d   = s1_spec_q.valid ? '0 : {s1_mant_big_q, 3'b000};
      s2_mant_small_d = s1_spec_q.valid ? '0 : align_small({s1_mant_small_q, 3'b000}, s1_diff_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q      <= 1'b0;
      s1_big_exp_q    <= '0;
      s1_sign_big_q   <= 1'b0;
      s1_sign_small_q <= 1'b0;
      s1_mant_big_q   <= '0;
      s1_mant_small_q <= '0;
      s1_diff_q       <= '0;
      s1_spec_q       <= '0;
      s2_valid_q      <= 1'b0;
      s2_big_exp_q    <= '0;
      s2_sign_big_q   <= 1'b0;
      s2_sign_small_q <= 1'b0;
      s2_mant_big_q   <= '0;
      s2_mant_small_q <= '0;
      s2_eff_sub_q    <= 1'b0;
      s2_spec_q       <= '0;
    end else begin
      s1_valid_q      <= s1_valid_d;
      s1_big_exp_q    <= s1_big_exp_d;
      s1_sign_big_q   <= s1_sign_big_d;
      s1_sign_small_q <= s1_sign_small_d;
      s1_mant_big_q   <= s1_mant_big_d;
      s1_mant_small_q <= s1_mant_small_d;
      s1_diff_q       <= s1_diff_d;
      s1_spec_q       <= s1_spec_d;
      s2_valid_q      <= s2_valid_d;
      s2_big_exp_q    <= s2_big_exp_d;
      s2_sign_big_q   <= s2_sign_big_d;
      s2_sign_small_q <= s2_sign_small_d;
      s2_mant_big_q   <= s2_mant_big_d;
      s2_mant_small_q <= s2_mant_small_d;
      s2_eff_sub_q    <= s2_eff_sub_d;
      s2_spec_q       <= s2_spec_d;
    end
  end

  assign out_bus.out_valid      = s2_valid_q;
  assign out_bus.big_exp        = s2_big_exp_q;
  assign out_bus.sign_big       = s2_sign_big_q;
  assign out_bus.sign_small     = s2_sign_small_q;
  assign out_bus.mant_big       = s2_mant_big_q;
  assign out_bus.mant_small     = s2_mant_small_q;
  assign out_bus.eff_sub        = s2_eff_sub_q;
  assign out_bus.special_valid  = s2_spec_q.valid;
  assign out_bus.special_result = s2_spec_q.result;
  assign out_bus.exceptions     = s2_spec_q.exc;
endmodule

// File: tb/tb_hp_align_stage.sv
// Scoreboard bench for hp_align_stage: directed operand pairs with hand-computed
// aligned results, back-pressure, flush and mid-flight reset.
module tb_hp_align_stage;
  typedef struct packed {
    logic [4:0]  be;
    logic        sb;
    logic        ss;
    logic [13:0] mb;
    logic [13:0] ms;
    logic        es;
    logic        sv;
    logic [15:0] sr;
    logic [1:0]  ex;
  } exp_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        op;
    exp_t        e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  vec_t vecs[15];

  hp_in_if  in_bus();
  hp_out_if out_bus();

  hp_align_stage #(.MW(14), .SH_MAX(13)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .in_bus  (in_bus),
    .out_bus (out_bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b, input logic op,
                              input logic [4:0] be, input logic sb, input logic ss,
                              input logic [13:0] mb, input logic [13:0] ms, input logic es,
                              input logic sv, input logic [15:0] sr, input logic [1:0] ex);
    vec_t v;
    v.a = a; v.b = b; v.op = op;
    v.e = '{be, sb, ss, mb, ms, es, sv, sr, ex};
    return v;
  endfunction

  function automatic exp_t get_out();
    return {out_bus.big_exp, out_bus.sign_big, out_bus.sign_small, out_bus.mant_big,
            out_bus.mant_small, out_bus.eff_sub, out_bus.special_valid,
            out_bus.special_result, out_bus.exceptions};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h @%0t", name, got, want, $time);
    end
  endtask

  // Pops and compares whenever the DUT hands over a result.
  task automatic monitor();
    exp_t snap;
    bit   pend = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 0;
      end else begin
        chk("in_ready", {63'b0, in_bus.in_ready},
            {63'b0, (exp_q.size() < 2) || out_bus.out_ready});
        if (pend) begin
          chk("hold_valid", {63'b0, out_bus.out_valid}, 64'd1);
          chk("hold_data", {9'b0, get_out()}, {9'b0, snap});
        end
        pend = 0;
        if (out_bus.out_valid && !out_bus.out_ready && !flush) begin
          pend = 1;
          snap = get_out();
        end
        if (out_bus.out_valid && out_bus.out_ready) begin
          if (exp_q.size() == 0) chk("spurious_out", 64'd1, 64'd0);
          else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("result", {9'b0, get_out()}, {9'b0, e});
          end
        end
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input vec_t v);
    int n;
    in_bus.hp_inA = v.a;
    in_bus.hp_inB = v.b;
    in_bus.op = v.op;
    in_bus.in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk); #1;
      if (in_bus.in_ready) break;
      n++;
      if (n > 100) begin
        chk("send_timeout", 64'd1, 64'd0);
        break;
      end
      @(posedge clk); #1;
    end
    if (n <= 100) exp_q.push_back(v.e);
    @(posedge clk); #1;
    in_bus.in_valid = 1'b0;
  endtask

  task automatic latency_check(input vec_t v);
    in_bus.hp_inA = v.a;
    in_bus.hp_inB = v.b;
    in_bus.op = v.op;
    in_bus.in_valid = 1'b1;
    @(negedge clk);
    chk("lat_c0_valid", {63'b0, out_bus.out_valid}, 64'd0);
    chk("lat_c0_ready", {63'b0, in_bus.in_ready}, 64'd1);
    #1 exp_q.push_back(v.e);
    @(posedge clk); #1;
    in_bus.in_valid = 1'b0;
    @(negedge clk);
    chk("lat_c1_valid", {63'b0, out_bus.out_valid}, 64'd0);
    @(negedge clk);
    chk("lat_c2_valid", {63'b0, out_bus.out_valid}, 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0]  = mk(16'h3C00, 16'h3C00, 0, 15, 0, 0, 14'h2000, 14'h2000, 0, 0, 16'h0000, 2'b00);
    vecs[1]  = mk(16'h3C00, 16'h4000, 1, 16, 1, 0, 14'h2000, 14'h1000, 1, 0, 16'h0000, 2'b00);
    vecs[2]  = mk(16'h7800, 16'h0001, 0, 30, 0, 0, 14'h2000, 14'h0001, 0, 0, 16'h0000, 2'b00);
    vecs[3]  = mk(16'h7C00, 16'hFC00, 0, 31, 0, 1, 14'h0000, 14'h0000, 1, 1, 16'h7E00, 2'b01);
    vecs[4]  = mk(16'h7C00, 16'h3C00, 1, 31, 0, 1, 14'h0000, 14'h0000, 1, 1, 16'h7C00, 2'b10);
    vecs[5]  = mk(16'h0000, 16'h8000, 1,  1, 0, 0, 14'h0000, 14'h0000, 0, 1, 16'h0000, 2'b00);
    vecs[6]  = mk(16'h8000, 16'h8000, 0,  1, 1, 1, 14'h0000, 14'h0000, 0, 1, 16'h8000, 2'b00);
    vecs[7]  = mk(16'h4000, 16'h3001, 0, 16, 0, 0, 14'h2000, 14'h0201, 0, 0, 16'h0000, 2'b00);
    vecs[8]  = mk(16'h4000, 16'h0C00, 0, 16, 0, 0, 14'h2000, 14'h0001, 0, 0, 16'h0000, 2'b00);
    vecs[9]  = mk(16'h4000, 16'h1000, 0, 16, 0, 0, 14'h2000, 14'h0002, 0, 0, 16'h0000, 2'b00);
    vecs[10] = mk(16'h3C00, 16'h7C01, 0, 31, 0, 0, 14'h0000, 14'h0000, 0, 1, 16'h7E00, 2'b01);
    vecs[11] = mk(16'h0200, 16'h0100, 0,  1, 0, 0, 14'h1000, 14'h0800, 0, 0, 16'h0000, 2'b00);
    vecs[12] = mk(16'h3C01, 16'hBC02, 0, 15, 1, 0, 14'h2010, 14'h2008, 1, 0, 16'h0000, 2'b00);
    vecs[13] = mk(16'h7C00, 16'h7C00, 1, 31, 0, 1, 14'h0000, 14'h0000, 1, 1, 16'h7E00, 2'b01);
    vecs[14] = mk(16'h3C00, 16'h7C00, 1, 31, 1, 0, 14'h0000, 14'h0000, 1, 1, 16'hFC00, 2'b10);

    rst_n = 1'b0;
    flush = 1'b0;
    in_bus.in_valid = 1'b0;
    in_bus.hp_inA = '0;
    in_bus.hp_inB = '0;
    in_bus.op = 1'b0;
    out_bus.out_ready = 1'b1;
    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {63'b0, out_bus.out_valid}, 64'd0);
    chk("rst_in_ready", {63'b0, in_bus.in_ready}, 64'd1);
    chk("rst_outputs", {9'b0, get_out()}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    latency_check(vecs[0]);
    @(posedge clk); #1;
    for (int i = 0; i < 15; i++) send(vecs[i]);
    drain();

    // Back-pressure: six ops back to back, sink stalls three cycles.
    fork
      for (int i = 7; i < 13; i++) send(vecs[i]);
      begin
        repeat (2) begin @(posedge clk); #1; end
        out_bus.out_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        out_bus.out_ready = 1'b1;
      end
    join
    drain();

    // Flush with two ops in flight.
    out_bus.out_ready = 1'b0;
    send(vecs[1]);
    send(vecs[2]);
    flush = 1'b1;
    @(negedge clk); #1;
    exp_q.delete();
    @(posedge clk); #1;
    flush = 1'b0;
    out_bus.out_ready = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", {63'b0, out_bus.out_valid}, 64'd0);
    chk("flush_in_ready", {63'b0, in_bus.in_ready}, 64'd1);
    @(posedge clk); #1;
    latency_check(vecs[12]);
    drain();

    // Asynchronous reset with two ops in flight.
    out_bus.out_ready = 1'b0;
    send(vecs[7]);
    send(vecs[3]);
    rst_n = 1'b0;
    @(negedge clk);
    chk("arst_out_valid", {63'b0, out_bus.out_valid}, 64'd0);
    chk("arst_in_ready", {63'b0, in_bus.in_ready}, 64'd1);
    #1 exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_bus.out_ready = 1'b1;
    @(negedge clk);
    chk("arst_rel_valid", {63'b0, out_bus.out_valid}, 64'd0);
    @(posedge clk); #1;
    latency_check(vecs[14]);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
